// File: rtl/btc_nonce_sched.sv
// btc_nonce_sched
//   Drives one shared SHA-256 compression core to compute Bitcoin
//   double-SHA-256 over a 640-bit header for NUM_NONCES consecutive nonces.
//   The header's first 512-bit block is compressed once per job to get the
//   midstate. Each nonce then takes two core runs:
//     P2: the padded second header block, starting from the midstate.
//     P3: the padded 256-bit first hash, starting from the standard IV.
//   Each result {nonce, hash} is presented on a valid/ready output port.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   start              job request, sampled only while idle
//   header[639:0]      header words 0..19, word t at [32t+31:32t]; word 19 unused
//   nonce_base[31:0]   first nonce of the job, sampled with start
//   busy, done         job in progress / one-cycle end-of-job pulse
//   out_valid/ready    result handshake; out_nonce, out_hash carry the result
//   core_start         one-cycle start pulse to the compression core
//   core_h_init        chaining input (core_alpha_init mirrors it)
//   core_block         512-bit message block, word t at [32t+31:32t]
//   core_done          one-cycle completion pulse; core_hash valid with it
//   dbg_state_o        current FSM state, for observation only
//
// Handshake: a result transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid rises, it stays high and
// out_nonce/out_hash stay constant until that transfer. out_valid never
// depends combinationally on out_ready.

module btc_nonce_sched #(
    parameter int NUM_NONCES = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [639:0] header,
    input  logic [31:0]  nonce_base,
    output logic         busy,
    output logic         done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_nonce,
    output logic [255:0] out_hash,
    output logic         core_start,
    output logic [255:0] core_h_init,
    output logic [255:0] core_alpha_init,
    output logic [511:0] core_block,
    input  logic         core_done,
    input  logic [255:0] core_hash,
    output logic [3:0]   dbg_state_o
);

    localparam int CNT_W = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NONCES - 1);

    // SHA-256 initial hash value; word 0 sits in the low bits.
    localparam logic [255:0] SHA_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        MID_GO   = 4'd1,
        MID_WAIT = 4'd2,
        P2_GO    = 4'd3,
        P2_WAIT  = 4'd4,
        P3_GO    = 4'd5,
        P3_WAIT  = 4'd6,
        EMIT     = 4'd7,
        FIN      = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [95:0]        hdr_tail_q, hdr_tail_d;   // header words 16..18
    logic [31:0]        nonce_q, nonce_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [255:0]       midstate_q, midstate_d;
    logic [511:0]       block_q, block_d;
    logic [255:0]       h_init_q, h_init_d;
    logic               core_start_q, core_start_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_nonce_q, out_nonce_d;
    logic [255:0]       out_hash_q, out_hash_d;

    // Second header block: words 16..18, nonce, then SHA padding for a
    // 640-bit message.
    function automatic logic [511:0] p2_block(input logic [95:0] tail,
                                              input logic [31:0] nonce);
        return {32'h00000280, 320'd0, 32'h80000000, nonce, tail};
    endfunction

    // Single block holding the 256-bit first hash plus padding.
    function automatic logic [511:0] p3_block(input logic [255:0] h);
        return {32'h00000100, 192'd0, 32'h80000000, h};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hdr_tail_q   <= '0;
            nonce_q      <= '0;
            count_q      <= '0;
            midstate_q   <= '0;
            block_q      <= '0;
            h_init_q     <= '0;
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_nonce_q  <= '0;
            out_hash_q   <= '0;
        end else begin
            state_q      <= state_d;
            hdr_tail_q   <= hdr_tail_d;
            nonce_q      <= nonce_d;
            count_q      <= count_d;
            midstate_q   <= midstate_d;
            block_q      <= block_d;
            h_init_q     <= h_init_d;
            core_start_q <= core_start_d;
            out_valid_q  <= out_valid_d;
            out_nonce_q  <= out_nonce_d;
            out_hash_q   <= out_hash_d;
        end
    end

    // The core operands are loaded on the transition into each *_GO state.
    // They are therefore stable through the GO cycle, the cycle before the
    // registered core_start pulse. That pulse appears in the first *_WAIT
    // cycle. The operands stay untouched until the matching core_done.
    // During P3 the block register doubles as the h2 store.
    always_comb begin
        state_d      = state_q;
        hdr_tail_d   = hdr_tail_q;
        nonce_d      = nonce_q;
        count_d      = count_q;
        midstate_d   = midstate_q;
        block_d      = block_q;
        h_init_d     = h_init_q;
        core_start_d = 1'b0;
        out_valid_d  = out_valid_q;
        out_nonce_d  = out_nonce_q;
        out_hash_d   = out_hash_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    hdr_tail_d = header[607:512];
                    nonce_d    = nonce_base;
                    count_d    = '0;
                    block_d    = header[511:0];
                    h_init_d   = SHA_IV;
                    state_d    = MID_GO;
                end
            end
            MID_GO: begin
                core_start_d = 1'b1;
                state_d      = MID_WAIT;
            end
            MID_WAIT: begin
                if (core_done) begin
                    midstate_d = core_hash;
                    h_init_d   = core_hash;
                    block_d    = p2_block(hdr_tail_q, nonce_q);
                    state_d    = P2_GO;
                end
            end
            P2_GO: begin
                core_start_d = 1'b1;
                state_d      = P2_WAIT;
            end
            P2_WAIT: begin
                if (core_done) begin
                    block_d  = p3_block(core_hash);
                    h_init_d = SHA_IV;
                    state_d  = P3_GO;
                end
            end
            P3_GO: begin
                core_start_d = 1'b1;
                state_d      = P3_WAIT;
            end
            P3_WAIT: begin
                if (core_done) begin
                    out_hash_d  = core_hash;
                    out_nonce_d = nonce_q;
                    out_valid_d = 1'b1;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (count_q == LAST_CNT) begin
                        state_d = FIN;
                    end else begin
                        count_d  = count_q + 1'b1;
                        nonce_d  = nonce_q + 32'd1;
                        block_d  = p2_block(hdr_tail_q, nonce_q + 32'd1);
                        h_init_d = midstate_q;
                        state_d  = P2_GO;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy            = (state_q != IDLE) && (state_q != FIN);
    assign done            = (state_q == FIN);
    assign out_valid       = out_valid_q;
    assign out_nonce       = out_nonce_q;
    assign out_hash        = out_hash_q;
    assign core_start      = core_start_q;
    assign core_h_init     = h_init_q;
    assign core_alpha_init = h_init_q;
    assign core_block      = block_q;
    assign dbg_state_o     = state_q;

endmodule
